commit_stage: RTL and testbench
===============================

COMMIT_STAGE -- requirements
Module: commit_stage

Interface
REQ-001 Parameter XLEN, default 32 (from shared package), datapath width.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 head_entry  input  ROB_ENTRY  current ROB head.
  - Fields: valid, PC[XLEN], dest_reg[5], value[XLEN], wr_mem, rd_mem, mem_addr[XLEN], mem_data[XLEN], mispredict, target_pc[XLEN], halt, illegal.
REQ-005 head_ready  input  1  head result complete and eligible to retire.
REQ-006 cmt_packet_out  output  COMMIT_PACKET  registered commit result.
  - Fields: valid, rob_pop, PC, dest_reg, value, reg_wr_en, mem_wr_en, mem_addr, mem_data, flush, flush_pc, halt, illegal, retire_count[XLEN].

Function
REQ-007 commit_fire SHALL = head_entry.valid & head_ready & (state==RUN).
REQ-008 The packet SHALL be registered; fields reflect the commit_fire cycle at the next rising edge; latency 1 cycle.
REQ-009 When commit_fire=0, cmt_packet_out SHALL hold all one-bit controls at 0 (valid, rob_pop, reg_wr_en, mem_wr_en, flush, halt, illegal).
  - Data fields SHALL hold their previous values.
REQ-010 On commit_fire, valid and rob_pop SHALL be 1 for exactly one cycle per retired entry; at most one retirement per cycle.
REQ-011 On commit_fire, PC, dest_reg, value, mem_addr and mem_data SHALL be copied from head_entry.
REQ-012 reg_wr_en SHALL = commit_fire & !wr_mem & (dest_reg!=0).
REQ-013 mem_wr_en SHALL = commit_fire & wr_mem; a store never writes the register file, whatever dest_reg holds.
REQ-014 Loads (rd_mem=1) SHALL retire as register writes per REQ-012.
REQ-015 flush SHALL = commit_fire & mispredict; flush_pc = target_pc; the instruction itself still retires normally.
REQ-016 halt SHALL = commit_fire & head_entry.halt; the FSM then goes RUN->HALTED.
REQ-017 illegal SHALL = commit_fire & head_entry.illegal; the FSM then goes RUN->HALTED.
REQ-018 FSM states SHALL be RUN and HALTED.
  - HALTED is sticky until reset.
  - No commit_fire occurs in HALTED regardless of inputs.
REQ-019 retire_count SHALL increment by 1 on every commit_fire and wrap modulo 2^XLEN.
  - Value in the packet = count including the current retirement.
REQ-020 head_ready=1 with head_entry.valid=0 SHALL produce no commit.
REQ-021 Inputs with X on head_entry while valid=0 SHALL NOT propagate X to the control bits.

Reset
REQ-022 Reset SHALL asynchronously clear all cmt_packet_out fields to 0, set state=RUN and retire_count=0.
REQ-023 A reset asserted mid-stream SHALL drop any commit pending that cycle; the first commit after deassertion reports retire_count=1.

Structure
REQ-024 XLEN, ROB_ENTRY and COMMIT_PACKET SHALL be defined as packed structs in the shared sys_defs package; the FSM state enum SHALL be local to the module.
REQ-025 Single module; no sub-module.
  - Combinational next-packet logic plus one always_ff block with asynchronous reset.

Verification
REQ-026 Reset held 2 cycles -> all packet fields 0, state RUN.
REQ-027 Store retire: valid=1, head_ready=1, wr_mem=1, dest_reg=5'b00001, mem_addr=0x100, mem_data=0xDEAD -> next edge: valid=1, mem_wr_en=1, reg_wr_en=0, mem_addr=0x100, retire_count=1.
REQ-028 ALU retire with dest_reg=3, value=0x2A, then dest_reg=0 -> first: reg_wr_en=1, value=0x2A; second: reg_wr_en=0, valid=1, retire_count=2.
REQ-029 head_ready=0 with valid=1 for 3 cycles -> valid=0 and retire_count unchanged; then head_ready=1 -> exactly one retirement.
REQ-030 Mispredict with target_pc=0x40 -> flush=1, flush_pc=0x40, for one cycle only.
REQ-031 halt=1 retire, then further valid&ready heads -> halt=1 once, no further valid packets until reset; after reset, commits resume with retire_count=1.

Source files
------------

// File: rtl/sys_defs.sv
// Shared machine-wide widths and the ROB-head / commit-packet record formats.
package sys_defs;

  localparam int XLEN = 32;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] PC;
    logic [4:0]      dest_reg;
    logic [XLEN-1:0] value;
    logic            wr_mem;
    logic            rd_mem;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_data;
    logic            mispredict;
    logic [XLEN-1:0] target_pc;
    logic            halt;
    logic            illegal;
  } ROB_ENTRY;

  typedef struct packed {
    logic            valid;
    logic            rob_pop;
    logic [XLEN-1:0] PC;
    logic [4:0]      dest_reg;
    logic [XLEN-1:0] value;
    logic            reg_wr_en;
    logic            mem_wr_en;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_data;
    logic            flush;
    logic [XLEN-1:0] flush_pc;
    logic            halt;
    logic            illegal;
    logic [XLEN-1:0] retire_count;
  } COMMIT_PACKET;

endpackage

// File: rtl/commit_stage.sv
// In-order commit: retires at most one ROB head per cycle into a registered
// commit packet; a retired halt or illegal instruction freezes retirement until reset.
module commit_stage
  import sys_defs::*;
#(
  parameter int XLEN = sys_defs::XLEN
) (
  input  logic         clock,
  input  logic         reset,
  input  ROB_ENTRY     head_entry,
  input  logic         head_ready,
  output COMMIT_PACKET cmt_packet_out
);

  typedef enum logic {RUN, HALTED} state_e;

  state_e       state, state_nxt;
  COMMIT_PACKET pkt_nxt;
  logic         commit_fire;

  // The packet's retire_count doubles as the running retirement counter.
  always_comb begin
    commit_fire = head_entry.valid & head_ready & (state == RUN);
    state_nxt   = state;
    pkt_nxt     = cmt_packet_out;

    pkt_nxt.valid     = commit_fire;
    pkt_nxt.rob_pop   = commit_fire;
    pkt_nxt.reg_wr_en = commit_fire & ~head_entry.wr_mem & (head_entry.dest_reg != 5'd0);
    pkt_nxt.mem_wr_en = commit_fire & head_entry.wr_mem;
    pkt_nxt.flush     = commit_fire & head_entry.mispredict;
    pkt_nxt.halt      = commit_fire & head_entry.halt;
    pkt_nxt.illegal   = commit_fire & head_entry.illegal;

    if (commit_fire) begin
      pkt_nxt.PC           = head_entry.PC;
      pkt_nxt.dest_reg     = head_entry.dest_reg;
      pkt_nxt.value        = head_entry.value;
      pkt_nxt.mem_addr     = head_entry.mem_addr;
      pkt_nxt.mem_data     = head_entry.mem_data;
      pkt_nxt.flush_pc     = head_entry.target_pc;
      pkt_nxt.retire_count = cmt_packet_out.retire_count + {{(XLEN-1){1'b0}}, 1'b1};
      if (head_entry.halt | head_entry.illegal)
        state_nxt = HALTED;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= RUN;
      cmt_packet_out <= '0;
    end else begin
      state          <= state_nxt;
      cmt_packet_out <= pkt_nxt;
    end
  end

endmodule

// File: tb/tb_commit_stage.sv
// Randomized and directed checks of commit_stage against a retirement-rule model.
module tb_commit_stage;
  import sys_defs::*;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  ROB_ENTRY     head_entry;
  logic         head_ready;
  COMMIT_PACKET cmt_packet_out;

  int n_tests = 0;
  int n_fail  = 0;

  // model state
  COMMIT_PACKET m_pkt;
  bit           m_halted;
  int unsigned  m_count;

  commit_stage #(.XLEN(XLEN)) dut (
    .clock          (clock),
    .reset          (reset),
    .head_entry     (head_entry),
    .head_ready     (head_ready),
    .cmt_packet_out (cmt_packet_out)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_pkt    = '0;
    m_halted = 1'b0;
    m_count  = 0;
  endfunction

  // Apply rules for one clock: what the packet must look like after the edge.
  function automatic void model_step(input ROB_ENTRY e, input logic r);
    bit fire;
    fire = (e.valid === 1'b1) && (r === 1'b1) && !m_halted;
    m_pkt.valid     = fire;
    m_pkt.rob_pop   = fire;
    m_pkt.reg_wr_en = fire && !e.wr_mem && (e.dest_reg != 0);
    m_pkt.mem_wr_en = fire && e.wr_mem;
    m_pkt.flush     = fire && e.mispredict;
    m_pkt.halt      = fire && e.halt;
    m_pkt.illegal   = fire && e.illegal;
    if (fire) begin
      m_count++;
      m_pkt.PC           = e.PC;
      m_pkt.dest_reg     = e.dest_reg;
      m_pkt.value        = e.value;
      m_pkt.mem_addr     = e.mem_addr;
      m_pkt.mem_data     = e.mem_data;
      m_pkt.flush_pc     = e.target_pc;
      m_pkt.retire_count = m_count;
      if (e.halt || e.illegal) m_halted = 1'b1;
    end
  endfunction

  task automatic cyc(input ROB_ENTRY e, input logic r);
    head_entry = e;
    head_ready = r;
    model_step(e, r);
    @(posedge clock);
    #1;
    chk("pkt", cmt_packet_out, m_pkt);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(posedge clock);
    @(posedge clock);
    #1;
    chk("reset_pkt", cmt_packet_out, '0);
    reset = 1'b0;
  endtask

  function automatic ROB_ENTRY rand_entry();
    ROB_ENTRY e;
    e.valid      = ($urandom_range(0, 3) != 0);
    e.PC         = $urandom;
    e.dest_reg   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
    e.value      = $urandom;
    e.wr_mem     = ($urandom_range(0, 3) == 0);
    e.rd_mem     = !e.wr_mem && ($urandom_range(0, 3) == 0);
    e.mem_addr   = $urandom;
    e.mem_data   = $urandom;
    e.mispredict = ($urandom_range(0, 7) == 0);
    e.target_pc  = $urandom;
    e.halt       = ($urandom_range(0, 40) == 0);
    e.illegal    = ($urandom_range(0, 40) == 0);
    return e;
  endfunction

  function automatic ROB_ENTRY alu(input logic [4:0] rd, input logic [31:0] v);
    ROB_ENTRY e = '0;
    e.valid    = 1'b1;
    e.PC       = 32'h1000 + {27'd0, rd};
    e.dest_reg = rd;
    e.value    = v;
    return e;
  endfunction

  initial begin
    ROB_ENTRY e;
    head_entry = '0;
    head_ready = 1'b0;
    model_reset();

    do_reset();

    // store: no register write even with dest_reg != 0
    e = '0; e.valid = 1; e.wr_mem = 1; e.dest_reg = 5'd1;
    e.mem_addr = 32'h100; e.mem_data = 32'hDEAD;
    cyc(e, 1'b1);
    chk("st_valid", cmt_packet_out.valid, 1);
    chk("st_mem_wr", cmt_packet_out.mem_wr_en, 1);
    chk("st_reg_wr", cmt_packet_out.reg_wr_en, 0);
    chk("st_addr", cmt_packet_out.mem_addr, 32'h100);
    chk("st_cnt", cmt_packet_out.retire_count, 1);

    // ALU writes rd=3, then rd=0 retires without a write
    cyc(alu(5'd3, 32'h2A), 1'b1);
    chk("alu_wr", cmt_packet_out.reg_wr_en, 1);
    chk("alu_val", cmt_packet_out.value, 32'h2A);
    cyc(alu(5'd0, 32'h55), 1'b1);
    chk("r0_wr", cmt_packet_out.reg_wr_en, 0);
    chk("r0_valid", cmt_packet_out.valid, 1);
    chk("r0_cnt", cmt_packet_out.retire_count, 3);

    // not ready for 3 cycles, then exactly one retirement
    for (int i = 0; i < 3; i++) begin
      cyc(alu(5'd7, 32'h77), 1'b0);
      chk("nr_valid", cmt_packet_out.valid, 0);
      chk("nr_cnt", cmt_packet_out.retire_count, 3);
    end
    cyc(alu(5'd7, 32'h77), 1'b1);
    chk("rdy_cnt", cmt_packet_out.retire_count, 4);
    cyc('0, 1'b0);
    chk("rdy_once", cmt_packet_out.valid, 0);

    // ready with invalid head: no commit
    cyc('0, 1'b1);
    chk("inv_valid", cmt_packet_out.valid, 0);

    // load retires as register write
    e = alu(5'd9, 32'h99); e.rd_mem = 1;
    cyc(e, 1'b1);
    chk("ld_wr", cmt_packet_out.reg_wr_en, 1);

    // mispredict flush for one cycle
    e = alu(5'd4, 32'h4); e.mispredict = 1; e.target_pc = 32'h40;
    cyc(e, 1'b1);
    chk("fl_flush", cmt_packet_out.flush, 1);
    chk("fl_pc", cmt_packet_out.flush_pc, 32'h40);
    cyc('0, 1'b0);
    chk("fl_once", cmt_packet_out.flush, 0);

    // halt: one halt packet, then frozen until reset
    e = alu(5'd2, 32'h2); e.halt = 1;
    cyc(e, 1'b1);
    chk("h_halt", cmt_packet_out.halt, 1);
    for (int i = 0; i < 4; i++) begin
      cyc(alu(5'd5, 32'h5), 1'b1);
      chk("h_frozen", cmt_packet_out.valid, 0);
    end
    do_reset();
    cyc(alu(5'd5, 32'h5), 1'b1);
    chk("h_resume_cnt", cmt_packet_out.retire_count, 1);

    // illegal also halts
    e = alu(5'd6, 32'h6); e.illegal = 1;
    cyc(e, 1'b1);
    chk("il_flag", cmt_packet_out.illegal, 1);
    cyc(alu(5'd5, 32'h5), 1'b1);
    chk("il_frozen", cmt_packet_out.valid, 0);

    // mid-stream reset drops the pending commit
    do_reset();
    cyc(alu(5'd8, 32'h8), 1'b1);
    head_entry = alu(5'd8, 32'h88);
    head_ready = 1'b1;
    #2 reset = 1'b1;
    model_reset();
    #1;
    chk("mid_async", cmt_packet_out, '0);
    @(posedge clock);
    #1;
    chk("mid_pkt", cmt_packet_out, '0);
    reset = 1'b0;
    cyc(alu(5'd8, 32'h8), 1'b1);
    chk("mid_cnt", cmt_packet_out.retire_count, 1);

    // random traffic with periodic resets to leave HALTED
    for (int i = 0; i < 400; i++) begin
      if (i % 80 == 79) do_reset();
      cyc(rand_entry(), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
